instr_fetch: RTL and testbench

Instruction fetch stage placed directly upstream of the instruction decoder and control unit. It owns the program counter, issues sequential read requests to the synchronous instruction memory, and buffers returned words with their PCs in a small FIFO. Instructions are handed to decode over a valid/ready handshake. Taken-branch redirects from the ALU stage flush the fetch stage.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch.sv | 159 +++++++++++++++
 tb/tb_instr_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the fetch stage and its instruction buffer.
//   XLEN          - datapath / address width
//   NOP_INSTR     - addi x0,x0,0; shown on instr_out whenever the buffer is empty
//   fetch_state_t - fetch-stage FSM states (HALT exists only when the
//                   FETCH_MISALIGN_TRAP_EN macro is defined)
//   fetch_entry_t - one buffered instruction together with its PC
//   align_word()  - clears the two low address bits
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      RESET_S = 2'd0,
      RUN     = 2'd1,
      FLUSH   = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      HALT    = 2'd3
`endif
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: first-word-fall-through FIFO of {pc, instr} entries.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   push, push_entry  - write an entry (ignored when full and not popping)
//   pop               - remove the head entry (ignored when empty)
//   flush             - empty the FIFO; wins over push and pop
//   count             - number of valid entries (0..DEPTH)
//   head              - oldest entry; contents undefined when count is 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;
   logic           do_push;
   logic           do_pop;

   assign do_pop  = pop && !flush && (count_reg != '0);
   // A full buffer can still take a push in the same cycle it pops.
   assign do_push = push && !flush && ((count_reg != FULL) || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_entry;
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the decoder.
// Owns the PC, issues sequential reads to a 1-cycle synchronous instruction
// memory, buffers {pc, instr} pairs and hands them out over valid/ready.
// A taken branch (bt) redirects the PC and flushes everything in flight.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   stall               - blocks new memory requests only
//   bt, branch_target   - redirect request and its target
//   imem_req, imem_addr - memory read request / address (always the PC)
//   imem_rdata          - read data, one cycle after the request
//   instr_out, pc_out   - head of buffer (NOP / RESET_PC when empty)
//   instr_valid         - buffer non-empty
//   instr_ready         - decoder accepts the head this cycle
//   fetch_trap          - sticky misaligned-target trap
// Build option: FETCH_MISALIGN_TRAP_EN. When defined, a misaligned branch
// target traps into HALT instead of redirecting; when undefined the target's
// low two bits are cleared and fetch_trap is constant 0.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              bt,
   input  logic [XLEN-1:0]   branch_target,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic [XLEN-1:0]   instr_out,
   output logic [XLEN-1:0]   pc_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_trap
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t     state_reg, state_next;
   logic [XLEN-1:0]  pc_reg, pc_next;
   logic [XLEN-1:0]  issue_pc_reg;
   logic             inflight_reg;
   logic             issue;
   logic             flush;
   logic             push;
   logic             pop;
   logic             room;
   logic [CW:0]      occupancy;
   logic [CW-1:0]    count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic [XLEN-1:0]  target;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic             trap_reg, trap_next;
   logic             misaligned;
   assign misaligned = (branch_target[1:0] != 2'b00);
   assign target     = branch_target;
`else
   assign target     = align_word(branch_target);
`endif

   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready;

   // Slots already owned: buffered entries plus the response still coming,
   // less the entry leaving this cycle. Issue only if a slot stays free.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
   assign room      = (occupancy < (CW+1)'(BUF_DEPTH));

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      issue      = 1'b0;
      flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_next  = trap_reg;
`endif
      case (state_reg)
         RESET_S: state_next = RUN;
         RUN, FLUSH: begin
            if (bt) begin
               flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (misaligned) begin
                  trap_next  = 1'b1;
                  state_next = HALT;
               end else begin
                  pc_next    = target;
                  state_next = FLUSH;
               end
`else
               pc_next    = target;
               state_next = FLUSH;
`endif
            end else begin
               state_next = RUN;
               issue      = !stall && room;
               if (issue) pc_next = pc_reg + 32'd4;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: state_next = HALT;
`endif
         default: state_next = RESET_S;
      endcase
   end

   // Responses are kept only in RUN: the FLUSH cycle's arrival belongs to the
   // abandoned path, and HALT writes nothing.
   assign push             = inflight_reg && (state_reg == RUN);
   assign push_entry.pc    = issue_pc_reg;
   assign push_entry.instr = imem_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= RESET_S;
         pc_reg       <= RESET_PC;
         issue_pc_reg <= RESET_PC;
         inflight_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         inflight_reg <= issue;
         if (issue) issue_pc_reg <= pc_reg;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) trap_reg <= 1'b0;
      else        trap_reg <= trap_next;
   end
   assign fetch_trap = trap_reg;
`else
   assign fetch_trap = 1'b0;
`endif

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head       (head)
   );

   assign imem_req  = issue;
   assign imem_addr = pc_reg;
   assign instr_out = instr_valid ? head.instr : NOP_INSTR;
   assign pc_out    = instr_valid ? head.pc    : RESET_PC;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
// (RESET_PC = 0, BUF_DEPTH = 2). The instruction memory model returns
// word_at(addr) one cycle after each request. Inputs change 1 ns after the
// rising edge; outputs are checked 2 ns after it.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        bt;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_trap;

   int checks = 0;
   int errors = 0;

   instr_fetch #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .bt            (bt),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .fetch_trap    (fetch_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0001;
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= word_at(imem_addr);
      else          imem_rdata <= 32'hBAD0_BAD0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; bt = 1'b0; branch_target = 32'h0; instr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({imem_req, imem_addr, fetch_trap} !== {1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_req got req=%0b addr=%h trap=%0b want 0/00000000/0", imem_req, imem_addr, fetch_trap);
      end
      checks++;
      if ({instr_valid, instr_out, pc_out} !== {1'b0, 32'h0000_0013, 32'h0}) begin
         errors++;
         $display("FAIL reset_out got valid=%0b instr=%h pc=%h want 0/00000013/00000000", instr_valid, instr_out, pc_out);
      end
      $display("reset: req=%0b valid=%0b instr=%h pc=%h", imem_req, instr_valid, instr_out, pc_out);
   endtask

   task automatic test_free_run();
      logic [31:0] exp_pc;
      reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL release_cycle_req got %0b want 0", imem_req);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         #1;
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(k - 1) * 32'd4}) begin
            errors++;
            $display("FAIL run_req k=%0d got req=%0b addr=%h want 1/%h", k, imem_req, imem_addr, 32'(k - 1) * 32'd4);
         end
         exp_pc = 32'(k - 3) * 32'd4;
         checks++;
         if (k < 3) begin
            if (instr_valid !== 1'b0) begin
               errors++;
               $display("FAIL run_latency k=%0d got valid=%0b want 0", k, instr_valid);
            end
         end else if ({instr_valid, pc_out, instr_out} !== {1'b1, exp_pc, word_at(exp_pc)}) begin
            errors++;
            $display("FAIL run_pc k=%0d got valid=%0b pc=%h instr=%h want 1/%h/%h", k, instr_valid, pc_out, instr_out, exp_pc, word_at(exp_pc));
         end
         $display("run k=%0d req=%0b addr=%h valid=%0b pc=%h", k, imem_req, imem_addr, instr_valid, pc_out);
      end
   endtask

   task automatic test_backpressure();
      for (int j = 0; j < 5; j++) begin
         tick();
         instr_ready = 1'b0;
         #1;
         checks++;
         if ({imem_req, instr_valid, pc_out} !== {1'b0, 1'b1, 32'h20}) begin
            errors++;
            $display("FAIL bp_hold j=%0d got req=%0b valid=%0b pc=%h want 0/1/00000020", j, imem_req, instr_valid, pc_out);
         end
         $display("bp hold j=%0d req=%0b pc=%h", j, imem_req, pc_out);
      end
      for (int j = 0; j < 6; j++) begin
         tick();
         instr_ready = 1'b1;
         #1;
         checks++;
         if ({instr_valid, pc_out} !== {1'b1, 32'h20 + 32'(j) * 32'd4}) begin
            errors++;
            $display("FAIL bp_release j=%0d got valid=%0b pc=%h want 1/%h", j, instr_valid, pc_out, 32'h20 + 32'(j) * 32'd4);
         end
         if (j == 0) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h28}) begin
               errors++;
               $display("FAIL bp_resume_req got req=%0b addr=%h want 1/00000028", imem_req, imem_addr);
            end
         end
         $display("bp release j=%0d valid=%0b pc=%h", j, instr_valid, pc_out);
      end
   endtask

   task automatic test_redirect();
      tick();
      bt = 1'b1; branch_target = 32'h100;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL redir_bt_req got %0b want 0", imem_req);
      end
      tick();
      bt = 1'b0;
      #1;
      checks++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
         errors++;
         $display("FAIL redir_n1 got valid=%0b req=%0b addr=%h want 0/1/00000100", instr_valid, imem_req, imem_addr);
      end
      tick();
      #1;
      checks++;
      if ({instr_valid, imem_addr} !== {1'b0, 32'h104}) begin
         errors++;
         $display("FAIL redir_n2 got valid=%0b addr=%h want 0/00000104", instr_valid, imem_addr);
      end
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, 32'h100, word_at(32'h100)}) begin
         errors++;
         $display("FAIL redir_n3 got valid=%0b pc=%h instr=%h want 1/00000100/%h", instr_valid, pc_out, instr_out, word_at(32'h100));
      end
      tick();
      #1;
      checks++;
      if (pc_out !== 32'h104) begin
         errors++;
         $display("FAIL redir_n4 got pc=%h want 00000104", pc_out);
      end
      $display("redirect: target 00000100 pc now %h", pc_out);
   endtask

   task automatic test_stall_and_bt();
      tick();
      stall = 1'b1; bt = 1'b1; branch_target = 32'h200;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stbt_req got %0b want 0", imem_req);
      end
      tick();
      bt = 1'b0;
      #1;
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b0, 1'b0, 32'h200}) begin
         errors++;
         $display("FAIL stbt_flush got req=%0b valid=%0b addr=%h want 0/0/00000200", imem_req, instr_valid, imem_addr);
      end
      for (int j = 0; j < 2; j++) begin
         tick();
         #1;
         checks++;
         if ({imem_req, instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL stbt_stalled j=%0d got req=%0b valid=%0b want 0/0", j, imem_req, instr_valid);
         end
      end
      tick();
      stall = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL stbt_resume got req=%0b addr=%h want 1/00000200", imem_req, imem_addr);
      end
      tick();
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out} !== {1'b1, 32'h200}) begin
         errors++;
         $display("FAIL stbt_deliver got valid=%0b pc=%h want 1/00000200", instr_valid, pc_out);
      end
      $display("stall+bt: delivered pc=%h", pc_out);
   endtask

   task automatic test_pc_wrap();
      tick();
      bt = 1'b1; branch_target = 32'hFFFF_FFFC;
      #1;
      tick();
      bt = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr);
      end
      tick();
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL wrap_addr1 got req=%0b addr=%h want 1/00000000", imem_req, imem_addr);
      end
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out} !== {1'b1, 32'hFFFF_FFFC}) begin
         errors++;
         $display("FAIL wrap_pc0 got valid=%0b pc=%h want 1/fffffffc", instr_valid, pc_out);
      end
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, 32'h0, word_at(32'h0)}) begin
         errors++;
         $display("FAIL wrap_pc1 got valid=%0b pc=%h instr=%h want 1/00000000/%h", instr_valid, pc_out, instr_out, word_at(32'h0));
      end
      $display("wrap: pc now %h", pc_out);
   endtask

   task automatic test_misaligned();
`ifdef FETCH_MISALIGN_TRAP_EN
      tick();
      bt = 1'b1; branch_target = 32'h102;
      #1;
      checks++;
      if (fetch_trap !== 1'b0) begin
         errors++;
         $display("FAIL trap_early got %0b want 0", fetch_trap);
      end
      tick();
      bt = 1'b0;
      #1;
      for (int j = 0; j < 5; j++) begin
         checks++;
         if ({fetch_trap, imem_req, instr_valid} !== 3'b100) begin
            errors++;
            $display("FAIL trap_halt j=%0d got trap=%0b req=%0b valid=%0b want 1/0/0", j, fetch_trap, imem_req, instr_valid);
         end
         $display("trap j=%0d trap=%0b req=%0b", j, fetch_trap, imem_req);
         tick();
         #1;
      end
`else
      tick();
      bt = 1'b1; branch_target = 32'h103;
      #1;
      tick();
      bt = 1'b0;
      #1;
      checks++;
      if ({imem_addr, fetch_trap} !== {32'h100, 1'b0}) begin
         errors++;
         $display("FAIL misalign_addr got addr=%h trap=%0b want 00000100/0", imem_addr, fetch_trap);
      end
      tick();
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out} !== {1'b1, 32'h100}) begin
         errors++;
         $display("FAIL misalign_pc got valid=%0b pc=%h want 1/00000100", instr_valid, pc_out);
      end
      $display("misaligned target 00000103 -> pc %h", pc_out);
`endif
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_trap} !==
          {1'b0, 32'h0, 1'b0, 32'h0000_0013, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL midreset got req=%0b addr=%h valid=%0b instr=%h pc=%h trap=%0b", imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_trap);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({imem_req, instr_valid} !== 2'b00) begin
         errors++;
         $display("FAIL midreset_release got req=%0b valid=%0b want 0/0", imem_req, instr_valid);
      end
      tick();
      #1;
      checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_first got req=%0b addr=%h valid=%0b want 1/00000000/0", imem_req, imem_addr, instr_valid);
      end
      tick();
      tick();
      #1;
      checks++;
      if ({instr_valid, pc_out, instr_out} !== {1'b1, 32'h0, word_at(32'h0)}) begin
         errors++;
         $display("FAIL midreset_deliver got valid=%0b pc=%h instr=%h want 1/00000000/%h", instr_valid, pc_out, instr_out, word_at(32'h0));
      end
      $display("mid reset: restart pc=%h", pc_out);
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_backpressure();
      test_redirect();
      test_stall_and_bt();
      test_pc_wrap();
      test_misaligned();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule
